// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around a 1-bit full-adder cell.
// Operands are captured on an accepted start and fed LSB first, one bit pair per clock,
// with the ripple carry held in a flip-flop. The result is presented with a one-cycle done.

// 1-bit full-adder cell; purely combinational.
module fulladder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum_c,
    output logic o_cout_c
);

    assign o_sum_c  = i_a ^ i_b ^ i_cin;
    assign o_cout_c = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               w_accept;
    logic               w_run;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_ps;
    logic [WIDTH-1:0]   w_ps_nxt;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;

    logic               w_fa_sum;
    logic               w_fa_cout;

    // Shared full-adder cell: current LSB pair plus the stored carry.
    fulladder u_fa (
        .i_a      (r_a_sh[0]),
        .i_b      (r_b_sh[0]),
        .i_cin    (r_carry),
        .o_sum_c  (w_fa_sum),
        .o_cout_c (w_fa_cout)
    );

    // Partial sum shifts right with the new bit entering at the MSB; the old LSB drops off.
    assign w_ps_nxt = WIDTH'({w_fa_sum, r_ps} >> 1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus accept/run/last qualifiers for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_run = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand shifters, carry flop, partial sum and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_ps    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_ps    <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_ps    <= w_ps_nxt;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Result registers: updated only on the edge that processes the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_ps_nxt;
            r_cout <= w_fa_cout;
        end
    end

    // Status flags registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign cout  = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8): transaction-level model plus directed vectors.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: an add is a busy window of W+1 cycles after acceptance; the last one is done.
    bit           m_idle = 1'b1;
    int           m_age  = 0;
    logic [W:0]   m_res  = '0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle <= 1'b1;
            m_age  <= 0;
            m_res  <= '0;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if (m_idle) begin
            if (start) begin
                m_idle <= 1'b0;
                m_age  <= 0;
                m_res  <= (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == W) {m_cout, m_sum} <= m_res;
            if (m_age + 1 == W + 1) m_idle <= 1'b1;
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("ready", 32'(ready), 32'(m_idle));
        chk("busy",  32'(busy),  32'(!m_idle));
        chk("done",  32'(done),  32'((!m_idle) && (m_age == W)));
        chk("sum",   32'(sum),   32'(m_sum));
        chk("cout",  32'(cout),  32'(m_cout));
    end

    // One add from IDLE: start for one edge, scramble inputs, wait (bounded) for done.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                           input logic [W-1:0] es, input logic ec, input string nm);
        int lat;
        bit seen;
        chk({nm, "_ready_pre"}, 32'(ready), 32'd1);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ta; b = W'($urandom); cin = ~tc;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(W));
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        @(posedge clk); #1;
        chk({nm, "_ready_after"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int t1;
        int t2;
        int cyc;
        logic [W:0] e;
        rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_sum",   32'(sum),   32'd0);
        chk("rst_cout",  32'(cout),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
        run_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "add_00_00_c");

        // Result hold through RUN, second start at cnt=3 ignored.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= int'(W); k++) begin
            chk("hold_sum", 32'(sum), 32'h01);
            chk("hold_cout", 32'(cout), 32'd0);
            if (k == 4) begin start = 1'b1; a = 8'hFF; end
            if (k == 5) start = 1'b0;
            @(posedge clk); #1;
        end
        chk("busy_start_done", 32'(done), 32'd1);
        chk("busy_start_sum", 32'(sum), 32'h46);
        chk("busy_start_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        chk("busy_start_ready", 32'(ready), 32'd1);
        chk("busy_start_done_low", 32'(done), 32'd0);

        // Reset at cnt=4 aborts the add without a done.
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_sum",   32'(sum),   32'd0);
        chk("abort_cout",  32'(cout),  32'd0);
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done",  32'(done),  32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "add_after_abort");

        // Back-to-back with start held: 9 done-low cycles separate the two pulses.
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h0F; b = 8'h01;
        t1 = -1; t2 = -1; cyc = 0;
        while (t2 < 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    chk("b2b_first_sum", 32'(sum), 32'h00);
                    chk("b2b_first_cout", 32'(cout), 32'd1);
                end else begin
                    t2 = cyc;
                    start = 1'b0;
                    chk("b2b_second_sum", 32'(sum), 32'h10);
                    chk("b2b_second_cout", 32'(cout), 32'd0);
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_latency", 32'(t1), 32'd8);
        chk("b2b_gap", 32'(t2 - t1 - 1), 32'd9);
        repeat (3) @(posedge clk);
        #1;

        // Strided operand sweep with both carry-in values.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int c = 0; c < 2; c++) begin
                    e = (W+1)'(ai * 17) + (W+1)'(bi * 17) + (W+1)'(c);
                    run_add(W'(ai * 17), W'(bi * 17), 1'(c), e[W-1:0], e[W], "sweep");
                end
            end
        end

        // Random operands.
        for (int r = 0; r < 64; r++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            e = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            run_add(ra, rb, rc, e[W-1:0], e[W], "random");
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
